// File: rtl/ifu_iccm_dma_arb.sv
// ICCM arbiter between instruction fetch and DMA slave accesses.
// Forces a fetch stall when DMA starves and times DMA read-valid.
module ifu_iccm_dma_arb #(
  parameter int unsigned MAX_WAIT    = 8,
  parameter int unsigned ICCM_RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  input  logic dma_write,
  input  logic ifc_dma_access_ok,
  output logic dma_ack,
  output logic iccm_dma_sel,
  output logic iccm_dma_rd_en,
  output logic iccm_dma_wr_en,
  output logic iccm_dma_rvalid,
  output logic dma_iccm_stall_any,
  output logic arb_starve_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    FORCE,
    ACCESS,
    GAP
  } state_e;

  state_e state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic wr_q, wr_d;
  logic first_q, first_d;
  logic [ICCM_RD_LAT-1:0] rd_pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      wr_q      <= 1'b0;
      first_q   <= 1'b0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wr_q      <= wr_d;
      first_q   <= first_d;
      rd_pipe_q[0] <= iccm_dma_rd_en;
      for (int i = 1; i < int'(ICCM_RD_LAT); i++)
        rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (dma_req && ifc_dma_access_ok) begin
          state_d = ACCESS;
        end else if (dma_req) begin
          state_d = WAIT;
          wcnt_d  = 8'd1;
        end
      end
      WAIT: begin
        if (!dma_req)
          state_d = IDLE;
        else if (ifc_dma_access_ok)
          state_d = ACCESS;
        else if (wcnt_q == 8'(MAX_WAIT))
          state_d = FORCE;
        else if (wcnt_q != 8'hFF)
          wcnt_d = wcnt_q + 8'd1;
      end
      FORCE: begin
        if (!dma_req)
          state_d = IDLE;
        else if (ifc_dma_access_ok)
          state_d = ACCESS;
      end
      ACCESS: state_d = GAP;
      GAP: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write flag is captured on grant so outputs never see dma_write directly
  assign wr_d    = (state_d == ACCESS) ? dma_write : wr_q;
  assign first_d = (state_d == FORCE) && (state_q != FORCE);

  always_comb begin
    dma_ack            = 1'b0;
    iccm_dma_sel       = 1'b0;
    iccm_dma_rd_en     = 1'b0;
    iccm_dma_wr_en     = 1'b0;
    dma_iccm_stall_any = 1'b0;
    if (state_q == ACCESS) begin
      dma_ack            = 1'b1;
      iccm_dma_sel       = 1'b1;
      iccm_dma_wr_en     = wr_q;
      iccm_dma_rd_en     = ~wr_q;
      dma_iccm_stall_any = 1'b1;
    end else if (state_q == FORCE) begin
      dma_iccm_stall_any = 1'b1;
    end
  end

  assign arb_starve_pulse = first_q;
  assign iccm_dma_rvalid  = rd_pipe_q[ICCM_RD_LAT-1];

endmodule

// File: tb/tb_ifu_iccm_dma_arb.sv
// Bench for ifu_iccm_dma_arb: directed scenarios then random traffic
// against a time-stamp based reference model.
module tb_ifu_iccm_dma_arb;

  localparam int MW  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dma_req = 1'b0;
  logic dma_write = 1'b0;
  logic ok = 1'b0;
  logic dma_ack, sel, rd_en, wr_en, rvalid, stall, pulse;

  int checks = 0;
  int errors = 0;

  int t = 0;
  bit pend = 0;
  int s_start = 0;
  int ack_time = -1;
  bit ack_wr = 0;
  int free_at = 0;
  int due_q[$];
  int n_acks = 0;
  int n_starve = 0;

  always #5 clk = ~clk;

  ifu_iccm_dma_arb #(.MAX_WAIT(MW), .ICCM_RD_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .dma_req(dma_req),
    .dma_write(dma_write),
    .ifc_dma_access_ok(ok),
    .dma_ack(dma_ack),
    .iccm_dma_sel(sel),
    .iccm_dma_rd_en(rd_en),
    .iccm_dma_wr_en(wr_en),
    .iccm_dma_rvalid(rvalid),
    .dma_iccm_stall_any(stall),
    .arb_starve_pulse(pulse)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @t=%0d: got %b, expected %b", tag, t, got, exp);
    end
  endtask

  // Reference: request timing expressed as cycle stamps
  task automatic model_step(input bit r, input bit rq, input bit w,
                            input bit k);
    if (r) begin
      pend = 0;
      ack_time = -1;
      free_at = t + 1;
      for (int i = due_q.size() - 1; i >= 0; i--)
        if (due_q[i] > t) due_q.delete(i);
    end else if (ack_time == t) begin
      if (!ack_wr) due_q.push_back(t + LAT);
      free_at = t + 2;
    end else if (pend) begin
      if (!rq) begin
        pend = 0;
        free_at = t + 1;
      end else if (k) begin
        pend = 0;
        ack_time = t + 1;
        ack_wr = w;
      end
    end else if (rq && t >= free_at) begin
      if (k) begin
        ack_time = t + 1;
        ack_wr = w;
      end else begin
        pend = 1;
        s_start = t;
      end
    end
  endtask

  task automatic drive(input bit r, input bit rq, input bit w, input bit k);
    bit e_ack, e_rv;
    rst = r;
    dma_req = rq;
    dma_write = w;
    ok = k;
    model_step(r, rq, w, k);
    @(posedge clk);
    #1;
    t++;
    e_ack = (ack_time == t);
    e_rv = 0;
    foreach (due_q[i]) if (due_q[i] == t) e_rv = 1;
    if (e_ack) n_acks++;
    if (pend && t == s_start + MW + 1) n_starve++;
    chk("ack", dma_ack, e_ack);
    chk("sel", sel, e_ack);
    chk("rd_en", rd_en, e_ack && !ack_wr);
    chk("wr_en", wr_en, e_ack && ack_wr);
    chk("rvalid", rvalid, e_rv);
    chk("stall", stall, e_ack || (pend && t > s_start + MW));
    chk("starve", pulse, pend && t == s_start + MW + 1);
  endtask

  initial begin
    bit holding;
    bit hw;
    int okp;
    // reset held with request pending
    repeat (3) drive(1, 1, 0, 1);
    // idle read
    drive(0, 1, 0, 1);
    repeat (4) drive(0, 0, 0, 1);
    // back-to-back writes
    repeat (9) drive(0, 1, 1, 1);
    repeat (2) drive(0, 0, 0, 1);
    // starvation then late ok
    repeat (12) drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    repeat (4) drive(0, 0, 0, 1);
    // ok races the wait limit
    repeat (MW) drive(0, 1, 1, 0);
    drive(0, 1, 1, 1);
    repeat (3) drive(0, 0, 0, 1);
    // abort in WAIT, abort in FORCE
    repeat (3) drive(0, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 0);
    repeat (MW + 3) drive(0, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 0);
    // reset between read ack and rvalid
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 1);
    chk("dir_acks", n_acks == 7, 1'b1);
    chk("dir_starve", n_starve == 2, 1'b1);

    holding = 0;
    hw = 0;
    for (int ph = 0; ph < 4; ph++) begin
      okp = (ph == 0) ? 90 : (ph == 1) ? 20 : (ph == 2) ? 4 : 50;
      for (int c = 0; c < 600; c++) begin
        bit r;
        if (dma_ack) holding = 0;
        if (!holding && $urandom_range(99) < 60) begin
          holding = 1;
          hw = 1'($urandom_range(1));
        end else if (holding && !dma_ack && $urandom_range(99) < 2) begin
          holding = 0;
        end
        r = ($urandom_range(999) < 5);
        if (r) holding = 0;
        drive(r, holding, hw, $urandom_range(99) < okp);
      end
    end
    chk("rand_starve", n_starve > 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
